tpm_sram_frontend: RTL and testbench
====================================

# tpm_sram_frontend

Request front-end for one `sky130_sram_1kbytes_1rw1r_8x1024_8` macro in the triple-ported memory. It takes one write port and two read ports (1W2R), each with a valid/ready handshake. Write and read A share macro port 0 (RW) through a fairness arbiter; read B uses macro port 1 (R). It resolves same-address write/read-B hazards, captures the macro's transient `dout` into stable response registers, and counts arbitration stalls.

## Interface
Parameters:
- `DATA_WIDTH`, 8, word width; must match the macro.
- `ADDR_WIDTH`, 10, address width; must match the macro.

Ports:
- `clk`  in  1  single clock; also drives macro `clk0` and `clk1` at top level.
- `rst_n`  in  1  asynchronous, active-low reset.
- `wr_valid` / `wr_ready`  in/out  1  write request handshake.
- `wr_addr`  in  ADDR_WIDTH  write address.
- `wr_data`  in  DATA_WIDTH  write data.
- `rda_valid` / `rda_ready`  in/out  1  read A request handshake.
- `rda_addr`  in  ADDR_WIDTH  read A address.
- `rda_rvalid`  out  1  read A response pulse.
- `rda_rdata`  out  DATA_WIDTH  read A data.
- `rdb_valid` / `rdb_ready`  in/out  1  read B request handshake.
- `rdb_addr`  in  ADDR_WIDTH  read B address.
- `rdb_rvalid`  out  1  read B response pulse.
- `rdb_rdata`  out  DATA_WIDTH  read B data.
- `sram_csb0`, `sram_web0`  out  1  macro port 0 chip select and write enable, both active-low.
- `sram_addr0`  out  ADDR_WIDTH  macro port 0 address.
- `sram_din0`  out  DATA_WIDTH  macro port 0 write data.
- `sram_dout0`  in  DATA_WIDTH  macro port 0 read data.
- `sram_csb1`  out  1  macro port 1 chip select, active-low.
- `sram_addr1`  out  ADDR_WIDTH  macro port 1 address.
- `sram_dout1`  in  DATA_WIDTH  macro port 1 read data.
- `stall_cnt`  out  16  saturating count of cycles in which a valid request was refused.

## Operation
- **Port 0 arbitration.** A 1-bit register `prio` selects the winner (0 = write, 1 = read A).
  - Only one requester valid: it is granted.
  - Both valid: the `prio` side is granted, and `prio` toggles on that cycle's edge.
  - No contention: `prio` holds.
- **Port 0 macro drive (combinational).**
  - Write grant: `sram_csb0=0`, `sram_web0=0`, `sram_addr0=wr_addr`, `sram_din0=wr_data`.
  - Read A grant: `sram_csb0=0`, `sram_web0=1`, `sram_addr0=rda_addr`.
  - Idle: `sram_csb0=1`, `sram_web0=1`. `sram_addr0` and `sram_din0` hold their last values.
- **Ready signals.**
  - `wr_ready` = write granted.
  - `rda_ready` = read A granted.
  - `rdb_ready` = 1 unless a hazard applies (see Configuration).
- **Hazard.** `wr_valid & wr_ready & rdb_valid & (wr_addr==rdb_addr)` in the same cycle.
- **Port 1 macro drive.** `sram_csb1 = !(rdb_valid & rdb_ready)`; `sram_addr1 = rdb_addr`.
- **Response capture.**
  - Pending flags `pend_a` and `pend_b` are set at the accept edge.
  - At the next edge, `sram_dout0` / `sram_dout1` (or forwarded data) is loaded into `rd*_rdata`, and `rd*_rvalid` pulses for one cycle.
  - `rd*_rdata` holds until the next response; the macro's X-after-hold is never visible.
  - Responses have no backpressure; the consumer must always accept.
- **`stall_cnt`.** Increments by the number of refused valid requests in the cycle (0–2) and saturates at 0xFFFF.
- **Reset (`rst_n` low).**
  - Outputs: `sram_csb0=sram_csb1=1`, `sram_web0=1`, all `*_ready=0`, `rd*_rvalid=0`, `rd*_rdata=0`, `stall_cnt=0`, `sram_addr*`/`sram_din0`=0.
  - State: `prio=0`; pending flags cleared.
  - Reset mid-operation discards in-flight reads with no response.

## Timing
- Requests are accepted on the rising edge with valid&ready. The macro samples the same edge and reads at the following negedge. Macro DELAY must be shorter than a half period.
- Read latency is exactly 1 cycle: `rd*_rvalid` is high in the cycle after acceptance.
- A write accepted at edge N is visible to a port-0 or port-1 read accepted at edge N+1 or later.
- Back-to-back reads on either port are supported every cycle.

## Configuration
- `TPM_FWD_EN` defined:
  - A hazard does not stall; `rdb_ready` stays 1.
  - Port 1 is not enabled for that read (`sram_csb1=1`).
  - The captured `wr_data` is returned on `rdb_rdata` with normal 1-cycle latency.
- `TPM_FWD_EN` undefined:
  - A hazard forces `rdb_ready=0` for that cycle and counts as a stall.
  - Read B reissues the next cycle and returns the newly written data.

## Test plan
- Reset: hold `rst_n` low with all valids high → `sram_csb0=sram_csb1=1`, all readies 0, `stall_cnt=0`.
- Write 0x5A to address 0x3FF, then read A from 0x3FF → `rda_rvalid` one cycle after accept, `rda_rdata=0x5A`.
- Write and read A both valid for 4 cycles → grants W,R,W,R; `stall_cnt=4`.
- Write 0xC3 to address 0x010 with read B of 0x010 in the same cycle:
  - `TPM_FWD_EN` defined: read B accepted, `rdb_rdata=0xC3` one cycle later.
  - `TPM_FWD_EN` undefined: `rdb_ready=0` for 1 cycle, then read B returns 0xC3.
- Read A and read B accepted on 0x001 and 0x002 every cycle for 8 cycles → 8 responses on each port with correct data and no gaps.
- Assert `rst_n` while `pend_a` is set → no `rda_rvalid` and `rda_rdata=0`; first read after release has latency 1.

Source files
------------

// File: rtl/tpm_sram_frontend_if.sv
// Request/response bundle for the 1W2R front-end: one write port and two read ports.
// master = requester side, slave = tpm_sram_frontend.
interface tpm_sram_frontend_if #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 10
);
    logic                  wr_valid;
    logic                  wr_ready;
    logic [ADDR_WIDTH-1:0] wr_addr;
    logic [DATA_WIDTH-1:0] wr_data;

    logic                  rda_valid;
    logic                  rda_ready;
    logic [ADDR_WIDTH-1:0] rda_addr;
    logic                  rda_rvalid;
    logic [DATA_WIDTH-1:0] rda_rdata;

    logic                  rdb_valid;
    logic                  rdb_ready;
    logic [ADDR_WIDTH-1:0] rdb_addr;
    logic                  rdb_rvalid;
    logic [DATA_WIDTH-1:0] rdb_rdata;

    modport master (
        output wr_valid, wr_addr, wr_data,
        input  wr_ready,
        output rda_valid, rda_addr,
        input  rda_ready, rda_rvalid, rda_rdata,
        output rdb_valid, rdb_addr,
        input  rdb_ready, rdb_rvalid, rdb_rdata
    );

    modport slave (
        input  wr_valid, wr_addr, wr_data,
        output wr_ready,
        input  rda_valid, rda_addr,
        output rda_ready, rda_rvalid, rda_rdata,
        input  rdb_valid, rdb_addr,
        output rdb_ready, rdb_rvalid, rdb_rdata
    );
endinterface

// File: rtl/tpm_sram_frontend.sv
// 1W2R front-end for one 1rw1r SRAM macro: write/read A share port 0 via a toggling arbiter, read B uses port 1.
// Latency: read response (rvalid + registered rdata) one cycle after the accept edge; no response backpressure.
// Backpressure: port-0 loser and same-address read B (TPM_FWD_EN undefined) see ready=0; TPM_FWD_EN forwards write data instead.
module tpm_sram_frontend #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 10
) (
    input  logic                  clk,
    input  logic                  rst_n,
    tpm_sram_frontend_if.slave    req,
    output logic                  sram_csb0,
    output logic                  sram_web0,
    output logic [ADDR_WIDTH-1:0] sram_addr0,
    output logic [DATA_WIDTH-1:0] sram_din0,
    input  logic [DATA_WIDTH-1:0] sram_dout0,
    output logic                  sram_csb1,
    output logic [ADDR_WIDTH-1:0] sram_addr1,
    input  logic [DATA_WIDTH-1:0] sram_dout1,
    output logic [15:0]           stall_cnt
);

`ifdef TPM_FWD_EN
    localparam bit FWD_EN = 1'b1;
`else
    localparam bit FWD_EN = 1'b0;
`endif

    logic                  prio_q, prio_d;
    logic [ADDR_WIDTH-1:0] addr0_q, addr0_d;
    logic [DATA_WIDTH-1:0] din0_q, din0_d;
    logic                  pend_a_q, pend_a_d;
    logic                  pend_b_q, pend_b_d;
    logic                  fwd_q, fwd_d;
    logic [DATA_WIDTH-1:0] fwd_dat_q, fwd_dat_d;
    logic                  rda_rvalid_q, rda_rvalid_d;
    logic [DATA_WIDTH-1:0] rda_rdata_q, rda_rdata_d;
    logic                  rdb_rvalid_q, rdb_rvalid_d;
    logic [DATA_WIDTH-1:0] rdb_rdata_q, rdb_rdata_d;
    logic [15:0]           stall_q, stall_d;

    logic                  gnt_w, gnt_a;
    logic                  hazard;
    logic                  rdb_rdy;
    logic                  rdb_acc;
    logic                  port1_en;
    logic [1:0]            refused;
    logic [16:0]           stall_sum;

    // Grants are gated by rst_n so every ready reads 0 while reset is held.
    always_comb begin
        gnt_w    = rst_n & req.wr_valid  & (~req.rda_valid | ~prio_q);
        gnt_a    = rst_n & req.rda_valid & (~req.wr_valid  |  prio_q);
        hazard   = gnt_w & req.rdb_valid & (req.wr_addr == req.rdb_addr);
        rdb_rdy  = rst_n & (FWD_EN | ~hazard);
        rdb_acc  = req.rdb_valid & rdb_rdy;
        port1_en = rdb_acc & ~hazard;
    end

    always_comb begin
        prio_d = prio_q;
        if (rst_n && req.wr_valid && req.rda_valid) begin
            prio_d = ~prio_q;
        end

        addr0_d = addr0_q;
        din0_d  = din0_q;
        if (gnt_w) begin
            addr0_d = req.wr_addr;
            din0_d  = req.wr_data;
        end else if (gnt_a) begin
            addr0_d = req.rda_addr;
        end

        pend_a_d  = gnt_a;
        pend_b_d  = rdb_acc;
        fwd_d     = rdb_acc & hazard;
        fwd_dat_d = hazard ? req.wr_data : fwd_dat_q;

        // Capture only on the edge after acceptance; dout is garbage at any other time.
        rda_rvalid_d = pend_a_q;
        rda_rdata_d  = pend_a_q ? sram_dout0 : rda_rdata_q;
        rdb_rvalid_d = pend_b_q;
        rdb_rdata_d  = rdb_rdata_q;
        if (pend_b_q) begin
            rdb_rdata_d = fwd_q ? fwd_dat_q : sram_dout1;
        end

        refused   = 2'(req.wr_valid  & ~gnt_w)
                  + 2'(req.rda_valid & ~gnt_a)
                  + 2'(req.rdb_valid & ~rdb_rdy);
        stall_sum = {1'b0, stall_q} + {15'b0, refused};
        stall_d   = stall_sum[16] ? 16'hFFFF : stall_sum[15:0];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            prio_q       <= 1'b0;
            addr0_q      <= '0;
            din0_q       <= '0;
            pend_a_q     <= 1'b0;
            pend_b_q     <= 1'b0;
            fwd_q        <= 1'b0;
            fwd_dat_q    <= '0;
            rda_rvalid_q <= 1'b0;
            rda_rdata_q  <= '0;
            rdb_rvalid_q <= 1'b0;
            rdb_rdata_q  <= '0;
            stall_q      <= '0;
        end else begin
            prio_q       <= prio_d;
            addr0_q      <= addr0_d;
            din0_q       <= din0_d;
            pend_a_q     <= pend_a_d;
            pend_b_q     <= pend_b_d;
            fwd_q        <= fwd_d;
            fwd_dat_q    <= fwd_dat_d;
            rda_rvalid_q <= rda_rvalid_d;
            rda_rdata_q  <= rda_rdata_d;
            rdb_rvalid_q <= rdb_rvalid_d;
            rdb_rdata_q  <= rdb_rdata_d;
            stall_q      <= stall_d;
        end
    end

    // Idle port 0 keeps the last driven address/data to avoid needless macro pin toggling.
    always_comb begin
        sram_csb0  = ~(gnt_w | gnt_a);
        sram_web0  = ~gnt_w;
        sram_addr0 = addr0_q;
        sram_din0  = din0_q;
        if (gnt_w) begin
            sram_addr0 = req.wr_addr;
            sram_din0  = req.wr_data;
        end else if (gnt_a) begin
            sram_addr0 = req.rda_addr;
        end
        sram_csb1  = ~port1_en;
        sram_addr1 = rst_n ? req.rdb_addr : '0;
    end

    assign req.wr_ready   = gnt_w;
    assign req.rda_ready  = gnt_a;
    assign req.rdb_ready  = rdb_rdy;
    assign req.rda_rvalid = rda_rvalid_q;
    assign req.rda_rdata  = rda_rdata_q;
    assign req.rdb_rvalid = rdb_rvalid_q;
    assign req.rdb_rdata  = rdb_rdata_q;
    assign stall_cnt      = stall_q;

endmodule

// File: tb/tb_tpm_sram_frontend.sv
// Randomized + directed bench for tpm_sram_frontend against a transaction-level reference model and a behavioural SRAM macro.
module tb_tpm_sram_frontend;
    localparam int DW = 8;
    localparam int AW = 10;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    tpm_sram_frontend_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus ();

    logic          sram_csb0, sram_web0, sram_csb1;
    logic [AW-1:0] sram_addr0, sram_addr1;
    logic [DW-1:0] sram_din0;
    logic [DW-1:0] sram_dout0 = '0;
    logic [DW-1:0] sram_dout1 = '0;
    logic [15:0]   stall_cnt;

    tpm_sram_frontend #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req        (bus.slave),
        .sram_csb0  (sram_csb0),
        .sram_web0  (sram_web0),
        .sram_addr0 (sram_addr0),
        .sram_din0  (sram_din0),
        .sram_dout0 (sram_dout0),
        .sram_csb1  (sram_csb1),
        .sram_addr1 (sram_addr1),
        .sram_dout1 (sram_dout1),
        .stall_cnt  (stall_cnt)
    );

    // Macro model: pins sampled at the rising edge, access at the following negedge, dout scrambled soon after the next edge.
    logic [DW-1:0] sram_mem [1024];
    logic          s_csb0 = 1'b1, s_web0 = 1'b1, s_csb1 = 1'b1;
    logic [AW-1:0] s_addr0 = '0, s_addr1 = '0;
    logic [DW-1:0] s_din0 = '0;

    always begin
        @(negedge clk);
        if (!s_csb0) begin
            if (!s_web0) sram_mem[s_addr0] = s_din0;
            else         sram_dout0 = sram_mem[s_addr0];
        end
        if (!s_csb1) sram_dout1 = sram_mem[s_addr1];
        s_csb0  = sram_csb0;
        s_web0  = sram_web0;
        s_addr0 = sram_addr0;
        s_din0  = sram_din0;
        s_csb1  = sram_csb1;
        s_addr1 = sram_addr1;
        @(posedge clk);
        #2;
        sram_dout0 = 8'($urandom);
        sram_dout1 = 8'($urandom);
    end

    // Reference model state
    logic [DW-1:0] ref_mem [1024];
    bit            read_wins_next;
    bit            pa_vld, pb_vld;
    logic [DW-1:0] pa_dat, pb_dat, last_a, last_b;
    int            exp_stall;

    int n_chk = 0;
    int n_err = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        read_wins_next = 1'b0;
        pa_vld = 1'b0;  pb_vld = 1'b0;
        last_a = '0;    last_b = '0;
        exp_stall = 0;
    endtask

    task automatic step(input bit wv, input logic [AW-1:0] wa, input logic [DW-1:0] wd,
                        input bit av, input logic [AW-1:0] aa,
                        input bit bv, input logic [AW-1:0] ba,
                        output bit gw, output bit ga, output bit gb);
        bit w_acc, a_acc, b_acc, haz;
        int refused;
        logic [DW-1:0] a_dat, b_dat;
        bus.wr_valid  = wv;  bus.wr_addr  = wa;  bus.wr_data = wd;
        bus.rda_valid = av;  bus.rda_addr = aa;
        bus.rdb_valid = bv;  bus.rdb_addr = ba;
        #1;
        w_acc = wv && (!av || !read_wins_next);
        a_acc = av && (!wv || read_wins_next);
        haz   = w_acc && bv && (wa == ba);
`ifdef TPM_FWD_EN
        b_acc = bv;
`else
        b_acc = bv && !haz;
`endif
        gw = bus.wr_ready;  ga = bus.rda_ready;  gb = bus.rdb_ready;
        check("wr_ready",  32'(bus.wr_ready),  32'(w_acc));
        check("rda_ready", 32'(bus.rda_ready), 32'(a_acc));
        if (bv) check("rdb_ready", 32'(bus.rdb_ready), 32'(b_acc));
        check("csb0", 32'(sram_csb0), 32'(!(w_acc || a_acc)));
        if (w_acc) check("web0", 32'(sram_web0), 32'd0);
        check("csb1", 32'(sram_csb1), 32'(!(b_acc && !haz)));
        refused = int'(wv && !w_acc) + int'(av && !a_acc) + int'(bv && !b_acc);
        a_dat = ref_mem[aa];
        b_dat = haz ? wd : ref_mem[ba];
        @(posedge clk);
        #1;
        check("rda_rvalid", 32'(bus.rda_rvalid), 32'(pa_vld));
        if (pa_vld) last_a = pa_dat;
        check("rda_rdata", 32'(bus.rda_rdata), 32'(last_a));
        check("rdb_rvalid", 32'(bus.rdb_rvalid), 32'(pb_vld));
        if (pb_vld) last_b = pb_dat;
        check("rdb_rdata", 32'(bus.rdb_rdata), 32'(last_b));
        pa_vld = a_acc;  pa_dat = a_dat;
        pb_vld = b_acc;  pb_dat = b_dat;
        if (w_acc) ref_mem[wa] = wd;
        if (wv && av) read_wins_next = !read_wins_next;
        exp_stall = (exp_stall + refused > 65535) ? 65535 : exp_stall + refused;
        check("stall_cnt", 32'(stall_cnt), 32'(exp_stall));
    endtask

    task automatic idle(output bit gw, output bit ga, output bit gb);
        step(1'b0, '0, '0, 1'b0, '0, 1'b0, '0, gw, ga, gb);
    endtask

    initial begin
        bit gw, ga, gb;
        logic [3:0] pat;
        int base, cnt_a, cnt_b;
        logic [DW-1:0] v;

        for (int i = 0; i < 1024; i++) begin
            v = 8'($urandom);
            ref_mem[i]  = v;
            sram_mem[i] = v;
        end
        model_reset();

        // Reset held with every requester active
        bus.wr_valid = 1'b1;  bus.wr_addr = 10'h011;  bus.wr_data = 8'hEE;
        bus.rda_valid = 1'b1; bus.rda_addr = 10'h011;
        bus.rdb_valid = 1'b1; bus.rdb_addr = 10'h011;
        repeat (2) @(posedge clk);
        #1;
        check("rst_csb0", 32'(sram_csb0), 32'd1);
        check("rst_csb1", 32'(sram_csb1), 32'd1);
        check("rst_web0", 32'(sram_web0), 32'd1);
        check("rst_readies", 32'({bus.wr_ready, bus.rda_ready, bus.rdb_ready}), 32'd0);
        check("rst_rvalids", 32'({bus.rda_rvalid, bus.rdb_rvalid}), 32'd0);
        check("rst_stall", 32'(stall_cnt), 32'd0);
        check("rst_addr0", 32'(sram_addr0), 32'd0);
        check("rst_addr1", 32'(sram_addr1), 32'd0);
        bus.wr_valid = 1'b0; bus.rda_valid = 1'b0; bus.rdb_valid = 1'b0;
        rst_n = 1'b1;

        // Write then read A at the top address
        step(1'b1, 10'h3FF, 8'h5A, 1'b0, '0, 1'b0, '0, gw, ga, gb);
        step(1'b0, '0, '0, 1'b1, 10'h3FF, 1'b0, '0, gw, ga, gb);
        idle(gw, ga, gb);
        check("rda_lat1_vld", 32'(bus.rda_rvalid), 32'd1);
        check("rda_5A", 32'(bus.rda_rdata), 32'h5A);

        // Write vs read A contention for four cycles
        base = exp_stall;
        pat = '0;
        for (int i = 0; i < 4; i++) begin
            step(1'b1, 10'(10'h100 + i), 8'(8'h30 + i), 1'b1, 10'h200, 1'b0, '0, gw, ga, gb);
            pat = {pat[2:0], gw};
        end
        check("arb_pattern", 32'(pat), 32'b1010);
        check("arb_stalls", 32'(stall_cnt), 32'(base + 4));
        idle(gw, ga, gb);

        // Same-address write / read B
        step(1'b1, 10'h010, 8'hC3, 1'b0, '0, 1'b1, 10'h010, gw, ga, gb);
`ifdef TPM_FWD_EN
        check("haz_rdb_ready", 32'(gb), 32'd1);
        idle(gw, ga, gb);
`else
        check("haz_rdb_ready", 32'(gb), 32'd0);
        step(1'b0, '0, '0, 1'b0, '0, 1'b1, 10'h010, gw, ga, gb);
        check("haz_reissue_ready", 32'(gb), 32'd1);
        idle(gw, ga, gb);
`endif
        check("haz_rdb_vld", 32'(bus.rdb_rvalid), 32'd1);
        check("haz_rdb_C3", 32'(bus.rdb_rdata), 32'hC3);

        // Back-to-back reads on both ports
        cnt_a = 0; cnt_b = 0;
        for (int i = 0; i < 8; i++) begin
            step(1'b0, '0, '0, 1'b1, 10'h001, 1'b1, 10'h002, gw, ga, gb);
            cnt_a += int'(bus.rda_rvalid);
            cnt_b += int'(bus.rdb_rvalid);
        end
        idle(gw, ga, gb);
        cnt_a += int'(bus.rda_rvalid);
        cnt_b += int'(bus.rdb_rvalid);
        check("b2b_count_a", 32'(cnt_a), 32'd8);
        check("b2b_count_b", 32'(cnt_b), 32'd8);

        // Reset while a read A is in flight
        step(1'b1, 10'h005, 8'h77, 1'b0, '0, 1'b0, '0, gw, ga, gb);
        step(1'b0, '0, '0, 1'b1, 10'h3FF, 1'b0, '0, gw, ga, gb);
        idle(gw, ga, gb);
        bus.rda_valid = 1'b1; bus.rda_addr = 10'h005;
        #1;
        check("midrst_accept", 32'(bus.rda_ready), 32'd1);
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        bus.rda_valid = 1'b0;
        #1;
        check("midrst_rdata0", 32'(bus.rda_rdata), 32'd0);
        @(posedge clk);
        #1;
        check("midrst_no_rvalid", 32'(bus.rda_rvalid), 32'd0);
        check("midrst_rdata_hold0", 32'(bus.rda_rdata), 32'd0);
        rst_n = 1'b1;
        model_reset();
        step(1'b0, '0, '0, 1'b1, 10'h005, 1'b0, '0, gw, ga, gb);
        idle(gw, ga, gb);
        check("postrst_lat1_vld", 32'(bus.rda_rvalid), 32'd1);
        check("postrst_data", 32'(bus.rda_rdata), 32'h77);

        // Random traffic over a small address window to provoke contention and hazards
        for (int i = 0; i < 400; i++) begin
            step($urandom_range(0, 9) < 6, 10'($urandom_range(0, 7)), 8'($urandom),
                 $urandom_range(0, 9) < 6, 10'($urandom_range(0, 7)),
                 $urandom_range(0, 9) < 6, 10'($urandom_range(0, 7)), gw, ga, gb);
        end
        idle(gw, ga, gb);
        idle(gw, ga, gb);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule
